// File: rtl/resp_gen.sv
// Response generator: merges single-cycle echo characters with fixed response
// strings (-OK, -ERR, -hhhh) into the UART character FIFO, one byte per cycle.
module resp_gen (
  input  logic        clk_rx,
  input  logic        rst_clk_rx,
  input  logic        send_char_val,
  input  logic [7:0]  send_char,
  input  logic        send_resp_val,
  input  logic [1:0]  send_resp_type,
  input  logic [15:0] send_resp_data,
  output logic        send_resp_done,
  input  logic        char_fifo_full,
  output logic [7:0]  char_fifo_din,
  output logic        char_fifo_wr_en
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SEND     = 2'd1,
    ST_WAIT_CLR = 2'd2
  } state_t;

  state_t      r_state;
  logic [1:0]  r_type;
  logic [15:0] r_data;
  logic [2:0]  r_idx;
  logic        r_done;
  logic [7:0]  r_din;
  logic        r_wr_en;

  logic [7:0]  w_byte;
  logic [2:0]  w_last_idx;
  logic        w_last;

  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
  endfunction

  // Type 2'b11 falls into the default branch and is sent as ERR.
  always_comb begin
    w_byte     = 8'h2D;
    w_last_idx = 3'd5;
    case (r_type)
      2'b00: begin
        w_last_idx = 3'd4;
        case (r_idx)
          3'd1:    w_byte = 8'h4F;
          3'd2:    w_byte = 8'h4B;
          3'd3:    w_byte = 8'h0D;
          3'd4:    w_byte = 8'h0A;
          default: w_byte = 8'h2D;
        endcase
      end
      2'b10: begin
        w_last_idx = 3'd6;
        case (r_idx)
          3'd1:    w_byte = hex_ascii(r_data[15:12]);
          3'd2:    w_byte = hex_ascii(r_data[11:8]);
          3'd3:    w_byte = hex_ascii(r_data[7:4]);
          3'd4:    w_byte = hex_ascii(r_data[3:0]);
          3'd5:    w_byte = 8'h0D;
          3'd6:    w_byte = 8'h0A;
          default: w_byte = 8'h2D;
        endcase
      end
      default: begin
        w_last_idx = 3'd5;
        case (r_idx)
          3'd1:    w_byte = 8'h45;
          3'd2:    w_byte = 8'h52;
          3'd3:    w_byte = 8'h52;
          3'd4:    w_byte = 8'h0D;
          3'd5:    w_byte = 8'h0A;
          default: w_byte = 8'h2D;
        endcase
      end
    endcase
  end

  assign w_last = (r_idx == w_last_idx);

  always_ff @(posedge clk_rx or posedge rst_clk_rx) begin
    if (rst_clk_rx) begin
      r_state <= ST_IDLE;
      r_type  <= 2'b00;
      r_data  <= 16'h0000;
      r_idx   <= 3'd0;
      r_done  <= 1'b0;
      r_din   <= 8'h00;
      r_wr_en <= 1'b0;
    end else begin
      r_wr_en <= 1'b0;
      r_done  <= 1'b0;
      // Echoes win the write port in every state; the parser has already gated them on full.
      if (send_char_val) begin
        r_wr_en <= 1'b1;
        r_din   <= send_char;
      end
      case (r_state)
        ST_IDLE: begin
          if (send_resp_val) begin
            r_type  <= send_resp_type;
            r_data  <= send_resp_data;
            r_idx   <= 3'd0;
            r_state <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (!send_char_val && !char_fifo_full) begin
            r_wr_en <= 1'b1;
            r_din   <= w_byte;
            r_idx   <= r_idx + 3'd1;
            if (w_last) begin
              r_done  <= 1'b1;
              r_state <= ST_WAIT_CLR;
            end
          end
        end
        ST_WAIT_CLR: begin
          if (!send_resp_val) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign send_resp_done  = r_done;
  assign char_fifo_din   = r_din;
  assign char_fifo_wr_en = r_wr_en;

endmodule

// File: tb/tb_resp_gen.sv
// Bench for resp_gen: directed test-plan scenarios followed by random traffic,
// all checked cycle by cycle against a string-queue reference model.
module tb_resp_gen;

  logic        clk_rx = 1'b0;
  logic        rst_clk_rx = 1'b0;
  logic        send_char_val = 1'b0;
  logic [7:0]  send_char = 8'h00;
  logic        send_resp_val = 1'b0;
  logic [1:0]  send_resp_type = 2'b00;
  logic [15:0] send_resp_data = 16'h0000;
  logic        send_resp_done;
  logic        char_fifo_full = 1'b0;
  logic [7:0]  char_fifo_din;
  logic        char_fifo_wr_en;

  resp_gen dut (
    .clk_rx          (clk_rx),
    .rst_clk_rx      (rst_clk_rx),
    .send_char_val   (send_char_val),
    .send_char       (send_char),
    .send_resp_val   (send_resp_val),
    .send_resp_type  (send_resp_type),
    .send_resp_data  (send_resp_data),
    .send_resp_done  (send_resp_done),
    .char_fifo_full  (char_fifo_full),
    .char_fifo_din   (char_fifo_din),
    .char_fifo_wr_en (char_fifo_wr_en)
  );

  always #5 clk_rx = ~clk_rx;

  typedef logic [7:0] bq_t[$];

  int   n_checks = 0;
  int   n_pass   = 0;

  // reference model: 0 idle, 1 sending, 2 waiting for request drop
  int   m_phase = 0;
  bq_t  m_q;
  logic exp_wr = 1'b0;
  logic exp_done = 1'b0;
  logic [7:0] exp_din = 8'h00;
  int   hold = 0;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, got, exp);
  endtask

  function automatic bq_t build(input logic [1:0] typ, input logic [15:0] d);
    bq_t   q;
    string s;
    case (typ)
      2'b00:   s = "-OK";
      2'b10:   begin s = $sformatf("%04x", d); s = s.toupper(); s = {"-", s}; end
      default: s = "-ERR";
    endcase
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    q.push_back(8'h0D);
    q.push_back(8'h0A);
    return q;
  endfunction

  task automatic model_edge();
    exp_wr   = 1'b0;
    exp_done = 1'b0;
    if (send_char_val) begin
      exp_wr  = 1'b1;
      exp_din = send_char;
    end
    case (m_phase)
      0: if (send_resp_val) begin
        m_q = build(send_resp_type, send_resp_data);
        m_phase = 1;
      end
      1: if (!send_char_val && !char_fifo_full) begin
        exp_wr  = 1'b1;
        exp_din = m_q.pop_front();
        if (m_q.size() == 0) begin
          exp_done = 1'b1;
          m_phase = 2;
        end
      end
      default: if (!send_resp_val) m_phase = 0;
    endcase
  endtask

  task automatic step();
    model_edge();
    @(posedge clk_rx);
    #1;
    chk("wr_en", 16'(char_fifo_wr_en), 16'(exp_wr));
    chk("din",   16'(char_fifo_din),   16'(exp_din));
    chk("done",  16'(send_resp_done),  16'(exp_done));
  endtask

  task automatic model_reset();
    m_q.delete();
    m_phase = 0;
    exp_din = 8'h00;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_wr_en"}, 16'(char_fifo_wr_en), 16'h0);
    chk({tag, "_din"},   16'(char_fifo_din),   16'h0);
    chk({tag, "_done"},  16'(send_resp_done),  16'h0);
  endtask

  // One parser-style request; hold = cycles val stays up after the done cycle.
  task automatic do_resp(input logic [1:0] typ, input logic [15:0] d, input logic [31:0] full_mask,
                         input int echo_k, input logic [7:0] echo_ch, input int hold_n,
                         input int exp_cyc, input string tag);
    int  k;
    logic got;
    send_resp_val  = 1'b1;
    send_resp_type = typ;
    send_resp_data = d;
    step();
    send_resp_type = ~typ;
    send_resp_data = ~d;
    k   = 0;
    got = 1'b0;
    while (!got && k < 30) begin
      k++;
      char_fifo_full = full_mask[k];
      send_char_val  = (k == echo_k);
      send_char      = echo_ch;
      step();
      send_char_val  = 1'b0;
      char_fifo_full = 1'b0;
      got = send_resp_done;
    end
    chk({tag, "_done_cycle"}, 16'(k), 16'(exp_cyc));
    for (int i = 0; i < hold_n; i++) step();
    send_resp_val = 1'b0;
    step();
    step();
  endtask

  initial begin
    #2 rst_clk_rx = 1'b1;
    #1 chk_reset_outputs("rst_init");
    repeat (2) @(posedge clk_rx);
    #1 rst_clk_rx = 1'b0;
    step();

    do_resp(2'b00, 16'h0000, 32'h0,  -1, 8'h00, 1, 5, "ok");
    do_resp(2'b01, 16'h1234, 32'h0,  -1, 8'h00, 1, 6, "err");
    do_resp(2'b10, 16'hA5F0, 32'h0,  -1, 8'h00, 1, 7, "data_a5f0");
    do_resp(2'b11, 16'hFFFF, 32'h0,  -1, 8'h00, 1, 6, "type11");
    do_resp(2'b00, 16'h0000, 32'h1C, -1, 8'h00, 1, 8, "ok_stall");
    do_resp(2'b00, 16'h0000, 32'h0,   3, 8'h57, 1, 6, "ok_echo");
    do_resp(2'b00, 16'h0000, 32'h0,  -1, 8'h00, 6, 5, "ok_hold");

    // async reset in the middle of a DATA string
    send_resp_val  = 1'b1;
    send_resp_type = 2'b10;
    send_resp_data = 16'h9C3E;
    step();
    step();
    step();
    rst_clk_rx = 1'b1;
    #1 chk_reset_outputs("rst_mid");
    model_reset();
    send_resp_val = 1'b0;
    @(posedge clk_rx);
    #1 rst_clk_rx = 1'b0;
    repeat (3) step();
    do_resp(2'b10, 16'h9C3E, 32'h0, -1, 8'h00, 0, 7, "data_after_rst");

    for (int i = 0; i < 3000; i++) begin
      send_char_val  = ($urandom % 100) < 15;
      send_char      = 8'($urandom);
      char_fifo_full = ($urandom % 100) < 20;
      if (m_phase == 0 && !send_resp_val && ($urandom % 100) < 30) begin
        send_resp_val  = 1'b1;
        send_resp_type = 2'($urandom);
        send_resp_data = 16'($urandom);
      end else if (m_phase == 1 && ($urandom % 4) == 0) begin
        send_resp_type = 2'($urandom);
        send_resp_data = 16'($urandom);
      end else if (m_phase == 2) begin
        if (hold == 0) send_resp_val = 1'b0;
        else hold--;
      end
      step();
      if (exp_done) hold = int'($urandom_range(0, 3));
    end

    send_char_val  = 1'b0;
    char_fifo_full = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (m_phase == 2) send_resp_val = 1'b0;
      step();
    end
    chk("drain_idle", 16'(m_phase), 16'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
